button_event_arbiter: RTL

Front-end controller for the board's push-buttons. It synchronizes and debounces N raw button inputs, each with its own counter, and turns debounced press edges into pending events. A round-robin arbiter then shares a single valid/ready event port among those buttons. It sits between the raw pins and the control FSM that consumes button commands.

---
 rtl/button_event_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Synchronizes and debounces N_BTN raw push-button levels, turns debounced
// edges into pending event flags and shares one valid/ready event port among
// the buttons with a round-robin arbiter.
//
// Optional feature macro: RELEASE_EVENT_EN
//   defined   -> release (1->0) edges also produce events, flagged with
//                evt_release=1.
//   undefined -> only press events; evt_release is constant 0.
//
// Handshake: evt_valid/evt_idx/evt_release are registered. Once evt_valid is
// high it stays high, and evt_idx/evt_release stay stable, until the cycle in
// which evt_ready is also high (the transfer happens on that rising edge).
// evt_ready is ignored while evt_valid is low.
module button_event_arbiter #(
  parameter int N_BTN     = 4,
  parameter int IDX_W     = 2,
  parameter int DB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_release
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] state_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] pend_rel;
  logic [N_BTN-1:0] clr_press;
  logic             handshake;
  logic [IDX_W-1:0] rr_ptr;
  state_t           state;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_rel;
  int               scan_pos;
  logic [IDX_W-1:0] scan_idx;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  // Per-button debounce: the synchronized level must disagree with the
  // debounced level for DB_CYCLES consecutive edges; any agreement restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_state <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q2[i] != btn_state[i]) begin
          if (cnt[i] == CNT_LAST) begin
            btn_state[i] <= ~btn_state[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise      = btn_state & ~state_d;
  assign handshake = evt_valid & evt_ready;

  // Clear request for the press flag that is being handed over this cycle.
  always_comb begin
    clr_press = '0;
    if (handshake && !evt_release) begin
      clr_press[evt_idx] = 1'b1;
    end
  end

  // Edge history and press flags; a new edge in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_d    <= '0;
      pend_press <= '0;
    end else begin
      state_d    <= btn_state;
      pend_press <= (pend_press & ~clr_press) | rise;
    end
  end

`ifdef RELEASE_EVENT_EN
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] clr_rel;

  assign fall = ~btn_state & state_d;

  // Clear request for the release flag that is being handed over.
  always_comb begin
    clr_rel = '0;
    if (handshake && evt_release) begin
      clr_rel[evt_idx] = 1'b1;
    end
  end

  // Release flags, same coalescing and set-wins rule as press flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rel <= '0;
    end else begin
      pend_rel <= (pend_rel & ~clr_rel) | fall;
    end
  end
`else
  assign pend_rel = '0;
`endif

  // Round-robin pick: first button with any pending flag at or after rr_ptr,
  // wrapping; a pending press beats a pending release on the same button.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rel   = 1'b0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan_pos = int'(rr_ptr) + k;
      if (scan_pos >= N_BTN) begin
        scan_pos = scan_pos - N_BTN;
      end
      scan_idx = IDX_W'(scan_pos);
      if (!sel_found && (pend_press[scan_idx] || pend_rel[scan_idx])) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
        sel_rel   = ~pend_press[scan_idx];
      end
    end
  end

  // Arbiter FSM: latch the pick in IDLE, hold it in OFFER until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      evt_valid   <= 1'b0;
      evt_idx     <= '0;
      evt_release <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            state       <= S_OFFER;
            evt_valid   <= 1'b1;
            evt_idx     <= sel_idx;
            evt_release <= sel_rel;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
            rr_ptr    <= (evt_idx == IDX_W'(N_BTN - 1)) ? '0 : evt_idx + IDX_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
